counter_step_decoder: RTL and testbench

//  Observes the count stream produced by the up/down counter and reconstructs
//  the control that produced it: per-sample enable (step) and direction.

---
 rtl/counter_step_decoder.sv | 150 +++++++++++++++
 tb/tb_counter_step_decoder.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/counter_step_decoder.sv
// ============================================================================
// counter_step_decoder: decodes step enable/direction from an up/down count
// stream and flags wraps, reversals and illegal jumps. Rev 1.0
// ============================================================================
`default_nettype none

module counter_step_decoder #(
  parameter int WIDTH = 4,
  parameter int ERR_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             sample_valid,
  input  logic [WIDTH-1:0] sum,
  input  logic             clear_err,
  output logic             step_valid,
  output logic             step_en,
  output logic             step_dir,
  output logic             wrap,
  output logic             dir_change,
  output logic             jump_err,
  output logic [WIDTH-1:0] run_len,
  output logic [ERR_W-1:0] err_count
);

  localparam logic [WIDTH-1:0] c_max     = '1;
  localparam logic [WIDTH-1:0] c_one     = WIDTH'(1);
  localparam logic [ERR_W-1:0] c_err_max = '1;
  localparam logic [ERR_W-1:0] c_err_one = ERR_W'(1);

  typedef enum logic [0:0] {
    S_EMPTY = 1'b0,
    S_TRACK = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic             have_dir_q, have_dir_d;
  logic             step_valid_q, step_valid_d;
  logic             step_en_q, step_en_d;
  logic             step_dir_q, step_dir_d;
  logic             wrap_q, wrap_d;
  logic             dir_change_q, dir_change_d;
  logic             jump_err_q, jump_err_d;
  logic [WIDTH-1:0] run_len_q, run_len_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;

  logic [WIDTH-1:0] w_delta;
  logic             w_up;
  logic             w_dir_change;
  logic [ERR_W-1:0] w_err_base;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= S_EMPTY;
      prev_q       <= '0;
      have_dir_q   <= 1'b0;
      step_valid_q <= 1'b0;
      step_en_q    <= 1'b0;
      step_dir_q   <= 1'b0;
      wrap_q       <= 1'b0;
      dir_change_q <= 1'b0;
      jump_err_q   <= 1'b0;
      run_len_q    <= '0;
      err_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      have_dir_q   <= have_dir_d;
      step_valid_q <= step_valid_d;
      step_en_q    <= step_en_d;
      step_dir_q   <= step_dir_d;
      wrap_q       <= wrap_d;
      dir_change_q <= dir_change_d;
      jump_err_q   <= jump_err_d;
      run_len_q    <= run_len_d;
      err_count_q  <= err_count_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    prev_d       = prev_q;
    have_dir_d   = have_dir_q;
    step_valid_d = 1'b0;
    step_en_d    = step_en_q;
    step_dir_d   = step_dir_q;
    wrap_d       = 1'b0;
    dir_change_d = 1'b0;
    jump_err_d   = 1'b0;
    run_len_d    = run_len_q;
    w_delta      = sum - prev_q;
    w_up         = (w_delta == c_one);
    w_dir_change = have_dir_q && (step_dir_q != w_up);
    // Clear takes effect before a same-cycle jump is counted.
    w_err_base   = clear_err ? '0 : err_count_q;
    err_count_d  = w_err_base;

    case (state_q)
      S_EMPTY: begin
        if (sample_valid) begin
          prev_d  = sum;
          state_d = S_TRACK;
        end
      end
      S_TRACK: begin
        if (sample_valid) begin
          step_valid_d = 1'b1;
          prev_d       = sum;
          if (w_delta == '0) begin
            step_en_d = 1'b0;
          end else if (w_delta == c_one || w_delta == c_max) begin
            step_en_d    = 1'b1;
            step_dir_d   = w_up;
            wrap_d       = w_up ? (prev_q == c_max) : (prev_q == '0);
            dir_change_d = w_dir_change;
            have_dir_d   = 1'b1;
            if (!have_dir_q || w_dir_change) begin
              run_len_d = c_one;
            end else if (run_len_q != c_max) begin
              run_len_d = run_len_q + c_one;
            end
          end else begin
            // Illegal jump: resync on this sample and forget direction history.
            step_en_d  = 1'b0;
            jump_err_d = 1'b1;
            have_dir_d = 1'b0;
            run_len_d  = '0;
            if (w_err_base != c_err_max) begin
              err_count_d = w_err_base + c_err_one;
            end
          end
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  assign step_valid = step_valid_q;
  assign step_en    = step_en_q;
  assign step_dir   = step_dir_q;
  assign wrap       = wrap_q;
  assign dir_change = dir_change_q;
  assign jump_err   = jump_err_q;
  assign run_len    = run_len_q;
  assign err_count  = err_count_q;

endmodule

`default_nettype wire

// File: tb/tb_counter_step_decoder.sv
// ============================================================================
// tb_counter_step_decoder: scoreboard bench with a behavioural reference
// model for counter_step_decoder. Rev 1.0
// ============================================================================
`default_nettype none

module tb_counter_step_decoder;

  localparam int WIDTH = 4;
  localparam int ERR_W = 8;
  localparam int MODV  = 1 << WIDTH;
  localparam int RMAX  = MODV - 1;
  localparam int EMAX  = (1 << ERR_W) - 1;

  logic             clock;
  logic             reset;
  logic             sample_valid;
  logic [WIDTH-1:0] sum;
  logic             clear_err;
  logic             step_valid;
  logic             step_en;
  logic             step_dir;
  logic             wrap;
  logic             dir_change;
  logic             jump_err;
  logic [WIDTH-1:0] run_len;
  logic [ERR_W-1:0] err_count;

  counter_step_decoder #(.WIDTH(WIDTH), .ERR_W(ERR_W)) dut (
    .clock(clock), .reset(reset), .sample_valid(sample_valid), .sum(sum),
    .clear_err(clear_err), .step_valid(step_valid), .step_en(step_en),
    .step_dir(step_dir), .wrap(wrap), .dir_change(dir_change),
    .jump_err(jump_err), .run_len(run_len), .err_count(err_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int en, dir, wrp, dchg, jerr, run, err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  bit m_primed, m_have, m_dir, m_en;
  int m_prev, m_run, m_err;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    m_primed = 0; m_have = 0; m_dir = 0; m_en = 0;
    m_prev = 0; m_run = 0; m_err = 0;
  endtask

  // One cycle of stimulus; expected response is queued for the monitor.
  task automatic drive(input bit v, input int s, input bit clr);
    exp_t e;
    int d;
    @(negedge clock);
    sample_valid = v;
    sum          = WIDTH'(s);
    clear_err    = clr;
    if (clr) m_err = 0;
    if (v) begin
      if (!m_primed) begin
        m_primed = 1;
        m_prev   = s % MODV;
      end else begin
        d = ((s % MODV) - m_prev + MODV) % MODV;
        e.wrp = 0; e.dchg = 0; e.jerr = 0;
        if (d == 0) begin
          m_en = 0;
        end else if (d == 1 || d == MODV - 1) begin
          bit up;
          up    = (d == 1);
          m_en  = 1;
          e.wrp = (up && m_prev == MODV - 1) || (!up && m_prev == 0);
          e.dchg = m_have && (up != m_dir);
          if (!m_have || e.dchg != 0) m_run = 1;
          else m_run = (m_run + 1 > RMAX) ? RMAX : m_run + 1;
          m_have = 1;
          m_dir  = up;
        end else begin
          m_en   = 0;
          e.jerr = 1;
          m_err  = (m_err + 1 > EMAX) ? EMAX : m_err + 1;
          m_have = 0;
          m_run  = 0;
        end
        m_prev = s % MODV;
        e.en = m_en; e.dir = m_dir; e.run = m_run; e.err = m_err;
        exp_q.push_back(e);
      end
    end
  endtask

  // Monitor: every step_valid pulse must match the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (reset) begin
        if (step_valid) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_step_valid actual=1 expected=0 at %0t", $time);
          end else begin
            e = exp_q.pop_front();
            chk("step_en",    int'(step_en),    e.en);
            chk("step_dir",   int'(step_dir),   e.dir);
            chk("wrap",       int'(wrap),       e.wrp);
            chk("dir_change", int'(dir_change), e.dchg);
            chk("jump_err",   int'(jump_err),   e.jerr);
            chk("run_len",    int'(run_len),    e.run);
            chk("err_count",  int'(err_count),  e.err);
          end
        end else begin
          chk("idle_pulses", int'({wrap, dir_change, jump_err}), 0);
          if (exp_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL missing_step_valid actual=0 expected=1 at %0t", $time);
            exp_q.delete();
          end
        end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_step_valid"}, int'(step_valid), 0);
    chk({tag, "_step_en"},    int'(step_en),    0);
    chk({tag, "_step_dir"},   int'(step_dir),   0);
    chk({tag, "_pulses"},     int'({wrap, dir_change, jump_err}), 0);
    chk({tag, "_run_len"},    int'(run_len),    0);
    chk({tag, "_err_count"},  int'(err_count),  0);
  endtask

  initial begin
    int p;
    reset = 1'b0; sample_valid = 1'b0; sum = '0; clear_err = 1'b0;
    model_reset();
    repeat (2) @(negedge clock);
    check_all_zero("reset");
    reset = 1'b1;

    // Count up through wrap and run_len saturation
    for (int i = 0; i <= 16; i++) drive(1, i % MODV, 0);
    // Up to 5, then reverse
    for (int i = 1; i <= 5; i++) drive(1, i, 0);
    drive(1, 4, 0);
    drive(1, 3, 0);
    // Holds
    drive(1, 7, 0); drive(1, 7, 0); drive(1, 7, 0);
    // Jump then recover
    drive(1, 3, 0); drive(1, 9, 0); drive(1, 10, 0);
    // Saturate the error counter
    for (int i = 0; i < 300; i++) drive(1, (i % 2) ? 8 : 0, 0);
    drive(0, 0, 1);
    @(negedge clock);
    chk("clear_alone_err_count", int'(err_count), m_err);
    drive(1, m_prev + 5, 1);
    drive(0, 0, 0);

    // Mid-stream asynchronous reset
    drive(1, 6, 0); drive(1, 7, 0); drive(0, 0, 0);
    @(negedge clock);
    #2;
    reset = 1'b0;
    #1;
    check_all_zero("async_reset");
    model_reset();
    @(negedge clock);
    reset = 1'b1;
    drive(1, 12, 0);
    drive(1, 13, 0);

    // Randomized stream biased toward legal steps
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 5))
        0:       p = 0;
        1, 2:    p = 1;
        3, 4:    p = MODV - 1;
        default: p = $urandom_range(2, MODV - 2);
      endcase
      drive($urandom_range(0, 9) != 0, (m_prev + p) % MODV,
            $urandom_range(0, 24) == 0);
    end
    drive(0, 0, 0);
    repeat (3) @(negedge clock);
    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
